// File: rtl/dac_pll_lock_supervisor.sv
// Closes the loop on the DAC PLL: pulses pll_rst, filters the synchronised locked flag, retries on timeout,
// and holds dac_rst until lock is stable. Outputs are registered from the next state (no extra latency).
module dac_pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_FILTER_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int MAX_RETRIES         = 3,
  parameter int LOL_CNT_W           = 8
) (
  input  logic                 refclk,
  input  logic                 rst,
  input  logic                 pll_locked,
  input  logic                 clear_status,
  output logic                 pll_rst,
  output logic                 dac_rst,
  output logic                 ready,
  output logic                 fault,
  output logic [LOL_CNT_W-1:0] lol_count
);

  localparam int RC_W = $clog2(PLL_RST_CYCLES + 1);
  localparam int FC_W = $clog2(LOCK_FILTER_CYCLES + 1);
  localparam int TC_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int RT_W = $clog2(MAX_RETRIES + 1);

  typedef enum logic [1:0] {
    S_PLL_RESET = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_RUN       = 2'd2,
    S_FAULT     = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      sync_q;
  logic            locked_s;
  logic [RC_W-1:0] rst_cnt;
  logic [FC_W-1:0] filt_cnt;
  logic [TC_W-1:0] to_cnt;
  logic [RT_W-1:0] retry_cnt;
  logic            rst_done, lock_done, timeout, retry_last;
  logic            pll_rst_nxt, dac_rst_nxt, ready_nxt, fault_nxt;

  assign locked_s   = sync_q[1];
  assign rst_done   = (rst_cnt == RC_W'(PLL_RST_CYCLES - 1));
  assign lock_done  = locked_s && (filt_cnt == FC_W'(LOCK_FILTER_CYCLES - 1));
  assign timeout    = (to_cnt == TC_W'(LOCK_TIMEOUT_CYCLES - 1));
  assign retry_last = (retry_cnt == RT_W'(MAX_RETRIES - 1));

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state   <= S_PLL_RESET;
      pll_rst <= 1'b1;
      dac_rst <= 1'b1;
      ready   <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pll_rst <= pll_rst_nxt;
      dac_rst <= dac_rst_nxt;
      ready   <= ready_nxt;
      fault   <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_PLL_RESET: if (rst_done) state_nxt = S_WAIT_LOCK;
      // lock takes priority over a coincident timeout
      S_WAIT_LOCK: begin
        if (lock_done)       state_nxt = S_RUN;
        else if (timeout)    state_nxt = retry_last ? S_FAULT : S_PLL_RESET;
      end
      S_RUN:       if (!locked_s) state_nxt = S_WAIT_LOCK;
      S_FAULT:     if (clear_status) state_nxt = S_PLL_RESET;
      default:     state_nxt = S_PLL_RESET;
    endcase
  end

  always_comb begin
    pll_rst_nxt = (state_nxt == S_PLL_RESET);
    dac_rst_nxt = (state_nxt != S_RUN);
    ready_nxt   = (state_nxt == S_RUN);
    fault_nxt   = (state_nxt == S_FAULT);
  end

  // Timers run only while the state is held, so every entry starts them from zero.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      rst_cnt   <= '0;
      filt_cnt  <= '0;
      to_cnt    <= '0;
      retry_cnt <= '0;
    end else begin
      rst_cnt <= (state == S_PLL_RESET && state_nxt == S_PLL_RESET) ? rst_cnt + RC_W'(1) : '0;
      if (state == S_WAIT_LOCK && state_nxt == S_WAIT_LOCK) begin
        filt_cnt <= locked_s ? filt_cnt + FC_W'(1) : '0;
        to_cnt   <= to_cnt + TC_W'(1);
      end else begin
        filt_cnt <= '0;
        to_cnt   <= '0;
      end
      if (state == S_WAIT_LOCK && lock_done)         retry_cnt <= '0;
      else if (state == S_WAIT_LOCK && timeout)      retry_cnt <= retry_cnt + RT_W'(1);
      else if (state == S_FAULT && clear_status)     retry_cnt <= '0;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lol_count <= '0;
    end else if (clear_status) begin
      lol_count <= '0;
    end else if (state == S_RUN && !locked_s && lol_count != '1) begin
      lol_count <= lol_count + LOL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dac_pll_lock_supervisor.sv
// Directed, table-driven bench for dac_pll_lock_supervisor with small sim parameters.
module tb_dac_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       clear_status = 1'b0;
  logic       pll_rst, dac_rst, ready, fault;
  logic [7:0] lol_count;

  int errors = 0;
  int checks = 0;

  always #5 refclk = ~refclk;

  dac_pll_lock_supervisor #(
    .PLL_RST_CYCLES(4),
    .LOCK_FILTER_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(64),
    .MAX_RETRIES(3),
    .LOL_CNT_W(8)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .pll_locked(pll_locked),
    .clear_status(clear_status),
    .pll_rst(pll_rst),
    .dac_rst(dac_rst),
    .ready(ready),
    .fault(fault),
    .lol_count(lol_count)
  );

  typedef struct {
    int         n;
    logic       locked;
    logic       clr;
    logic       e_pll;
    logic       e_dac;
    logic       e_rdy;
    logic       e_flt;
    logic [7:0] e_lol;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic lk, input logic clr, input logic p,
                     input logic d, input logic r, input logic f, input logic [7:0] l);
    vec_t v;
    v.n = n; v.locked = lk; v.clr = clr;
    v.e_pll = p; v.e_dac = d; v.e_rdy = r; v.e_flt = f; v.e_lol = l;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic p, input logic d, input logic r,
                     input logic f, input logic [7:0] l);
    checks++;
    if ({pll_rst, dac_rst, ready, fault, lol_count} !== {p, d, r, f, l}) begin
      errors++;
      $display("FAIL %s: got pll_rst=%b dac_rst=%b ready=%b fault=%b lol=%0d, want %b %b %b %b %0d",
               name, pll_rst, dac_rst, ready, fault, lol_count, p, d, r, f, l);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  // One-cycle dropout while in RUN; clear_status optionally lands on the loss edge.
  task automatic loss(input logic clr_on_loss, input logic [7:0] exp_lol, input bit do_chk);
    pll_locked = 1'b0; step();
    pll_locked = 1'b1; step();
    clear_status = clr_on_loss; step();
    clear_status = 1'b0;
    if (do_chk) chk("loss_edge", 1'b0, 1'b1, 1'b0, 1'b0, exp_lol);
    for (int i = 0; i < 8; i++) step();
    if (do_chk) chk("loss_relock", 1'b0, 1'b0, 1'b1, 1'b0, exp_lol);
  endtask

  initial begin
    // 1: lock after power-up
    add(3, 0, 0, 1, 1, 0, 0, 0);
    add(6, 0, 0, 0, 1, 0, 0, 0);
    add(9, 1, 0, 0, 1, 0, 0, 0);
    add(3, 1, 0, 0, 0, 1, 0, 0);
    // 2: single-cycle dropout in RUN
    add(1, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 0);
    add(8, 1, 0, 0, 1, 0, 0, 1);
    add(2, 1, 0, 0, 0, 1, 0, 1);
    // 3: lock never returns -> three retries then FAULT
    add(2,  0, 0, 0, 0, 1, 0, 1);
    add(64, 0, 0, 0, 1, 0, 0, 2);
    add(4,  0, 0, 1, 1, 0, 0, 2);
    add(64, 0, 0, 0, 1, 0, 0, 2);
    add(4,  0, 0, 1, 1, 0, 0, 2);
    add(64, 0, 0, 0, 1, 0, 0, 2);
    add(5,  0, 0, 0, 1, 0, 1, 2);
    add(1,  0, 1, 1, 1, 0, 0, 0);
    add(3,  0, 0, 1, 1, 0, 0, 0);
    // 4: 7 highs, 1 low, then 8 highs needed
    add(7, 1, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0);
    add(9, 1, 0, 0, 1, 0, 0, 0);
    add(2, 1, 0, 0, 0, 1, 0, 0);

    step(); step();
    chk("reset_state", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      for (int c = 0; c < vecs[k].n; c++) begin
        pll_locked   = vecs[k].locked;
        clear_status = vecs[k].clr;
        step();
        chk($sformatf("vec%0d_cyc%0d", k, c), vecs[k].e_pll, vecs[k].e_dac,
            vecs[k].e_rdy, vecs[k].e_flt, vecs[k].e_lol);
      end
    end
    clear_status = 1'b0;

    // 5: saturation and clear-wins
    for (int i = 1; i <= 255; i++) loss(1'b0, 8'(i), i == 1 || i == 255);
    loss(1'b0, 8'd255, 1'b1);
    loss(1'b1, 8'd0, 1'b1);

    // 6a: async reset mid-RUN
    loss(1'b0, 8'd1, 1'b0);
    #2 rst = 1'b1;
    #1 chk("arst_in_run", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("restart_pll_hi", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    step();
    chk("restart_pll_lo", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    // 6b: async reset mid-WAIT_LOCK
    step(); step();
    #2 rst = 1'b1;
    #1 chk("arst_in_wait", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 11; i++) step();
    chk("relock_not_yet", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    step();
    chk("relock_run", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1);
  end

endmodule
